// File: rtl/iram_burst_loader_if.sv
// iram_burst_loader_if: control, source-stream and IRAM write-port signals of the burst loader
interface iram_burst_loader_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9,
   parameter int CNT_W  = 8
);
   logic              start;
   logic              abort;
   logic [ADDR_W-1:0] base_addr;
   logic [CNT_W-1:0]  length;
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;
   logic              iram_we;
   logic [ADDR_W-1:0] iram_addr;
   logic [DATA_W-1:0] iram_wdata;
   logic              busy;
   logic              done_pulse;
   logic [31:0]       flag_reg;
   modport master (
      output start, abort, base_addr, length, in_valid, in_data,
      input  in_ready, iram_we, iram_addr, iram_wdata, busy, done_pulse, flag_reg
   );
   modport slave (
      input  start, abort, base_addr, length, in_valid, in_data,
      output in_ready, iram_we, iram_addr, iram_wdata, busy, done_pulse, flag_reg
   );
endinterface

// File: rtl/iram_burst_loader.sv
// iram_burst_loader: streams a range-checked, abortable burst of words into the IRAM write port
module iram_burst_loader #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 9,
   parameter int ADDR_STEP = 4,
   parameter int MAX_LEN   = 128,
   parameter int CNT_W     = $clog2(MAX_LEN + 1)
) (
   input logic clk,
   input logic rst_n,
   iram_burst_loader_if.slave bus
);
   localparam int EW = ADDR_W + CNT_W + $clog2(ADDR_STEP + 1) + 2;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t            state;
   logic [ADDR_W-1:0] ptr;
   logic [CNT_W-1:0]  rem;
   logic [CNT_W-1:0]  cnt;
   logic              done_f;
   logic              rerr_f;
   logic              abrt_f;
   logic [EW-1:0]     end_addr;
   logic              bad;
   assign bus.in_ready   = state == RUN;
   assign bus.busy       = state != IDLE;
   assign bus.done_pulse = state == DONE;
   assign bus.flag_reg   = {16'(cnt), 12'd0, abrt_f, rerr_f, done_f, state != IDLE};
   // last address of the requested burst at full width, so an overrun cannot alias back into range
   always_comb begin
      end_addr = (EW'(bus.length) - EW'(1)) * EW'(ADDR_STEP) + EW'(bus.base_addr);
      bad      = bus.length == '0 || bus.length > CNT_W'(MAX_LEN) || |end_addr[EW-1:ADDR_W];
   end
   // burst FSM: launch/reject in IDLE, one registered IRAM write per accepted word in RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         ptr            <= '0;
         rem            <= '0;
         cnt            <= '0;
         done_f         <= 1'b0;
         rerr_f         <= 1'b0;
         abrt_f         <= 1'b0;
         bus.iram_we    <= 1'b0;
         bus.iram_addr  <= '0;
         bus.iram_wdata <= '0;
      end else begin
         bus.iram_we <= 1'b0;
         case (state)
            IDLE: if (bus.start) begin
               done_f <= 1'b0;
               abrt_f <= 1'b0;
               rerr_f <= bad;
               if (!bad) begin
                  cnt   <= '0;
                  ptr   <= bus.base_addr;
                  rem   <= bus.length;
                  state <= RUN;
               end
            end
            RUN: if (bus.abort) begin
               abrt_f <= 1'b1;
               state  <= IDLE;
            end else if (bus.in_valid) begin
               bus.iram_we    <= 1'b1;
               bus.iram_addr  <= ptr;
               bus.iram_wdata <= bus.in_data;
               ptr            <= ptr + ADDR_W'(ADDR_STEP);
               rem            <= rem - CNT_W'(1);
               cnt            <= cnt + CNT_W'(1);
               if (rem == CNT_W'(1)) state <= DONE;
            end
            DONE: begin
               done_f <= 1'b1;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_iram_burst_loader.sv
// tb_iram_burst_loader: scoreboard bench for the IRAM burst loader
module tb_iram_burst_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int n_chk = 0;
   int n_pass = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   logic [40:0] sb[$];
   logic [40:0] e;
   iram_burst_loader_if #(.DATA_W(32), .ADDR_W(9), .CNT_W(8)) bus ();
   iram_burst_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   // write monitor: every IRAM write must match the oldest expected {addr,data}
   always @(negedge clk) begin
      if (bus.done_pulse) done_cnt++;
      if (bus.iram_we) begin
         wr_cnt++;
         if (sb.size() == 0) check("unexpected_write", 32'(bus.iram_addr), 32'hFFFF_FFFF);
         else begin
            e = sb.pop_front();
            check("wr_addr", 32'(bus.iram_addr), 32'(e[40:32]));
            check("wr_data", bus.iram_wdata, e[31:0]);
         end
      end
   end
   task automatic run_burst(input logic [8:0] b, input logic [7:0] l, input logic [31:0] vm,
                            input int ab, input logic [31:0] dbase, input logic [31:0] exp_flag);
      int i, c, w0, p0;
      logic ab_hit;
      i = 0; c = 0; w0 = wr_cnt; p0 = done_cnt; ab_hit = 1'b0;
      bus.base_addr = b; bus.length = l; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      check("run_ready", 32'(bus.in_ready), 32'd1);
      while (i < int'(l) && !ab_hit && c < 64) begin
         bus.in_valid = vm[c % 32];
         bus.in_data = dbase + 32'(i);
         if (bus.in_valid && ab == i) begin
            bus.abort = 1'b1;
            ab_hit = 1'b1;
         end else if (bus.in_valid) begin
            sb.push_back({b + 9'(i * 4), dbase + 32'(i)});
            i++;
         end
         @(posedge clk); #1;
         c++;
      end
      bus.in_valid = 1'b0;
      bus.abort = 1'b0;
      if (!ab_hit) begin
         check("done_pulse", 32'(bus.done_pulse), 32'd1);
         check("done_busy", 32'(bus.busy), 32'd1);
         @(posedge clk); #1;
      end
      check("idle_busy", 32'(bus.busy), 32'd0);
      check("idle_ready", 32'(bus.in_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("flag_reg", bus.flag_reg, exp_flag);
      check("write_count", 32'(wr_cnt - w0), ab < 0 ? 32'(l) : 32'(ab));
      check("done_count", 32'(done_cnt - p0), 32'(ab < 0));
      check("sb_empty", 32'(sb.size()), 32'd0);
   endtask
   task automatic reject(input logic [8:0] b, input logic [7:0] l);
      int w0;
      w0 = wr_cnt;
      bus.base_addr = b; bus.length = l; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      check("rej_busy", 32'(bus.busy), 32'd0);
      check("rej_ready", 32'(bus.in_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      check("rej_flag", 32'(bus.flag_reg[15:0]), 32'h0004);
      check("rej_writes", 32'(wr_cnt - w0), 32'd0);
   endtask
   initial begin
      int w0;
      bus.start = 1'b0; bus.abort = 1'b0; bus.base_addr = '0; bus.length = '0;
      bus.in_valid = 1'b0; bus.in_data = '0;
      #1;
      check("rst_we", 32'(bus.iram_we), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_ready", 32'(bus.in_ready), 32'd0);
      check("rst_done", 32'(bus.done_pulse), 32'd0);
      check("rst_flag", bus.flag_reg, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      run_burst(9'h010, 8'd4, 32'hFFFF_FFFF, -1, 32'h0000_00A0, 32'h0004_0002);
      run_burst(9'h040, 8'd3, 32'b101001, -1, $urandom, 32'h0003_0002);
      reject(9'h1F8, 8'd4);
      reject(9'h000, 8'd0);
      reject(9'h000, 8'd129);
      run_burst(9'h000, 8'd8, 32'hFFFF_FFFF, 3, $urandom, 32'h0003_0008);
      run_burst(9'h1F0, 8'd4, 32'hFFFF_FFFF, -1, $urandom, 32'h0004_0002);
      w0 = wr_cnt;
      bus.base_addr = 9'h020; bus.length = 8'd8; bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      bus.in_valid = 1'b1; bus.in_data = 32'hC0DE_0000;
      sb.push_back({9'h020, 32'hC0DE_0000});
      @(posedge clk); #1;
      bus.in_data = 32'hC0DE_0001;
      sb.push_back({9'h024, 32'hC0DE_0001});
      bus.base_addr = 9'h100; bus.length = 8'd2; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.in_valid = 1'b0;
      check("busy_start_ignored", 32'(bus.busy), 32'd1);
      check("mid_we", 32'(bus.iram_we), 32'd1);
      @(negedge clk); #1 rst_n = 1'b0;
      #1;
      check("arst_we", 32'(bus.iram_we), 32'd0);
      check("arst_busy", 32'(bus.busy), 32'd0);
      check("arst_ready", 32'(bus.in_ready), 32'd0);
      check("arst_flag", bus.flag_reg, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      check("arst_writes", 32'(wr_cnt - w0), 32'd2);
      check("arst_sb_empty", 32'(sb.size()), 32'd0);
      run_burst(9'h080, 8'd5, 32'b10110111, -1, $urandom, 32'h0005_0002);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/iram_burst_loader.md
# iram_burst_loader

Parametrised instruction loader that streams a burst of instruction words from a valid/ready source into the instruction RAM write port. Software programs a base address and word count, then pulses `start`. The block sustains one IRAM write per cycle, checks the burst against the IRAM address range, supports abort, and reports progress in a 32-bit status/flag register. It sits between the host-register interface and the IRAM write port.

## Interface
- `DATA_W`, 32, instruction word width.
- `ADDR_W`, 9, IRAM address width.
- `ADDR_STEP`, 4, address increment per word.
- `MAX_LEN`, 128, maximum burst length in words.
- `CNT_W`, $clog2(MAX_LEN+1), width of the length and count fields (derived).

- `clk`  in  1  clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- `abort`  in  1  terminate the running burst; sampled only in RUN.
- `base_addr`  in  ADDR_W  first IRAM address; sampled with `start`.
- `length`  in  CNT_W  number of words; sampled with `start`.
- `in_valid`  in  1  source word valid.
- `in_data`  in  DATA_W  source instruction word.
- `in_ready`  out  1  loader accepts a word.
- `iram_we`  out  1  IRAM write enable.
- `iram_addr`  out  ADDR_W  IRAM write address.
- `iram_wdata`  out  DATA_W  IRAM write data.
- `busy`  out  1  high when the state is not IDLE.
- `done_pulse`  out  1  one-cycle pulse when a burst completes normally.
- `flag_reg`  out  32  status word: [0] busy, [1] done (sticky), [2] range_err (sticky), [3] aborted (sticky), [15:4] zero, [31:16] words written, zero-extended.

## Operation
- States: IDLE, RUN, DONE. Reset forces IDLE. All outputs are 0 at reset; `flag_reg` is 0 at reset.
- In IDLE, when `start`=1:
  - Compute `end = base_addr + (length-1)*ADDR_STEP`, at full width with no truncation.
  - If `length`==0, `length`>MAX_LEN, or `end` > 2^ADDR_W-1: set `range_err`, clear `done` and `aborted`, and stay in IDLE. No writes occur.
  - Otherwise: clear `done`, `range_err`, `aborted` and the word count; load the address pointer with `base_addr` and the remaining count with `length`; go to RUN.
- In RUN:
  - `in_ready`=1, decoded combinationally from the state.
  - Each cycle with `in_valid`&&`in_ready` registers one write: on the next cycle `iram_we`=1, `iram_addr`=pointer, `iram_wdata`=`in_data`.
  - After each accepted word, pointer += ADDR_STEP, remaining -= 1, and words written += 1.
  - A cycle with `in_valid`=0 produces `iram_we`=0 on the next cycle.
  - When the last word is accepted (remaining==1), go to DONE.
- In DONE: `in_ready`=0, `done_pulse`=1, set sticky `done`, then go to IDLE. DONE always lasts exactly one cycle.
- `abort` in RUN: go to IDLE and set `aborted`. A word accepted in the same cycle as `abort` is discarded (no write). Writes already issued stand, and the word count reflects them.
- If `abort` and the last-word accept occur in the same cycle, `abort` wins: no write for that word, no `done`.
- `start` outside IDLE is ignored. `abort` outside RUN is ignored.
- The pointer never wraps, because the range check guarantees `end` stays within the address space.

## Timing
- `start` at edge N: RUN during cycle N+1, and `in_ready` is high in cycle N+1.
- Word accepted at edge k: `iram_we` is high for exactly cycle k+1, with address and data stable for that cycle.
- The last word accepted at edge k gives DONE and the final `iram_we` in the same cycle k+1. The state is IDLE at k+2.
- Latency start-to-done with back-to-back input is `length`+1 cycles. Throughput is 1 word/cycle.
- `flag_reg` is registered and updates the cycle after the causing event. Bit [0] mirrors `busy`.
- Asynchronous reset mid-burst: state goes to IDLE immediately and all outputs go to 0, including `iram_we`. The partial burst is not resumed.

## Test plan
- Basic burst: base 0x010, length 4, in_valid held high, data A0..A3 -> writes at 0x010, 0x014, 0x018, 0x01C on consecutive cycles; `done_pulse` once; flag_reg = 0x0004_0002.
- Backpressure: length 3 with in_valid toggled 1,0,0,1,0,1 -> exactly 3 writes, no `iram_we` in gap cycles, addresses contiguous, `done` set.
- Range reject: base 0x1F8, length 4, step 4 (end 0x204) -> no RUN, no writes, flag_reg[2]=1; repeat with length 0 -> same result.
- Abort: length 8, abort asserted after 3 accepts with a 4th word offered that cycle -> 3 writes, IDLE next, flag_reg = 0x0003_0008.
- Boundary fit: base 0x1F0, length 4 (end 0x1FC) -> accepted; last write at 0x1FC.
- Reset mid-burst, plus `start` pulsed while busy: start ignored; rst_n low after 2 writes -> `iram_we`/`busy`/`flag_reg` 0 at once; new burst after reset runs normally.
